// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, reset constants and the IF/ID record.
// Imported by the IF stage and reused by the ID stage.
package pipe_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned IF_ID_W   = 1 + 32 + 32;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDiscard
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    // Redirect targets are always word addresses; low bits from ID are not trusted.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_reg.sv
// One-entry skid register holding {instr, pc+4} for a fetch that completed while ID stalled.
module if_skid_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drop,
    input  logic [31:0] din_instr,
    input  logic [31:0] din_pc4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc4   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= din_instr;
            pc4   <= din_pc4;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, imem request handshake, IF/ID register and
// a skid entry that catches fetch data arriving while ID is stalled.
module if_fetch_unit
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  disc_q, disc_d;
    if_id_t       ifid_q, ifid_d;

    logic         skid_load, skid_drop, skid_valid;
    logic [31:0]  skid_instr, skid_pc4;
    logic [31:0]  pc_inc;

    assign pc_inc = pc_q + 32'd4;

    if_skid_reg u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .drop      (skid_drop),
        .din_instr (imem_rdata),
        .din_pc4   (pc_inc),
        .valid     (skid_valid),
        .instr     (skid_instr),
        .pc4       (skid_pc4)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        disc_d    = disc_q;
        ifid_d    = ifid_q;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (stall) begin
                    if (imem_ack) begin
                        skid_load = 1'b1;
                        state_d   = StHold;
                    end
                end else if (redirect) begin
                    ifid_d.valid = 1'b0;
                    ifid_d.instr = NOP_INSTR;
                    pc_d         = pc_align(npc);
                    if (!imem_ack) begin
                        // Request already on the bus must complete at its original address.
                        disc_d  = pc_q;
                        state_d = StDiscard;
                    end
                end else if (imem_ack) begin
                    ifid_d = '{valid: 1'b1, instr: imem_rdata, pc: pc_inc};
                    pc_d   = pc_inc;
                end else begin
                    ifid_d.valid = 1'b0;
                end
            end
            StHold: begin
                if (!stall) begin
                    skid_drop = 1'b1;
                    state_d   = StFetch;
                    if (redirect) begin
                        ifid_d.valid = 1'b0;
                        ifid_d.instr = NOP_INSTR;
                        pc_d         = pc_align(npc);
                    end else begin
                        ifid_d = '{valid: skid_valid, instr: skid_instr, pc: skid_pc4};
                        pc_d   = pc_inc;
                    end
                end
            end
            StDiscard: begin
                if (imem_ack) state_d = StFetch;
                if (!stall) begin
                    ifid_d.valid = 1'b0;
                    if (redirect) pc_d = pc_align(npc);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            disc_q    <= RESET_PC;
            ifid_q    <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0};
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            disc_q    <= disc_d;
            ifid_q    <= ifid_d;
            imem_req  <= (state_d == StFetch) || (state_d == StDiscard);
            imem_addr <= (state_d == StDiscard) ? disc_d : pc_d;
        end
    end

    assign if_id_valid = ifid_q.valid;
    assign if_id_instr = ifid_q.instr;
    assign if_id_pc    = ifid_q.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory returns addr ^ constant so each fetched word is
// traceable to its address; every step checks hand-computed outputs.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_ack;
    logic [31:0] npc, imem_rdata;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_instr, if_id_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .npc         (npc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc)
    );

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_rdata = w(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] instr, input logic [31:0] pc);
        chk({tag, ".req"},   {31'b0, imem_req},    {31'b0, req});
        chk({tag, ".addr"},  imem_addr,            addr);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, vld});
        chk({tag, ".instr"}, if_id_instr,          instr);
        chk({tag, ".pc"},    if_id_pc,             pc);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; npc = '0; imem_ack = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 32'h3000, 1'b0, 32'h0, 32'h0);

        rst = 1'b0;
        tick();
        chk_out("first_req", 1'b1, 32'h3000, 1'b0, 32'h0, 32'h0);

        // Same-cycle-ack memory: one instruction per cycle.
        imem_ack = 1'b1;
        tick();
        chk_out("stream0", 1'b1, 32'h3004, 1'b1, w(32'h3000), 32'h3004);
        tick();
        chk_out("stream1", 1'b1, 32'h3008, 1'b1, w(32'h3004), 32'h3008);

        // Slow memory: bubbles while waiting, address held.
        imem_ack = 1'b0;
        tick();
        chk_out("wait0", 1'b1, 32'h3008, 1'b0, w(32'h3004), 32'h3008);
        tick();
        chk_out("wait1", 1'b1, 32'h3008, 1'b0, w(32'h3004), 32'h3008);
        imem_ack = 1'b1;
        tick();
        chk_out("late_ack", 1'b1, 32'h300C, 1'b1, w(32'h3008), 32'h300C);

        // Stall over an ack: data into skid, HOLD drops the request.
        stall = 1'b1;
        tick();
        chk_out("hold0", 1'b0, 32'h300C, 1'b1, w(32'h3008), 32'h300C);
        tick();
        chk_out("hold1", 1'b0, 32'h300C, 1'b1, w(32'h3008), 32'h300C);
        tick();
        chk_out("hold2", 1'b0, 32'h300C, 1'b1, w(32'h3008), 32'h300C);
        stall = 1'b0;
        tick();
        chk_out("unstall", 1'b1, 32'h3010, 1'b1, w(32'h300C), 32'h3010);

        // Redirect on an acked fetch: word dropped, next request at target.
        redirect = 1'b1; npc = 32'h3100;
        tick();
        chk_out("redir_ack", 1'b1, 32'h3100, 1'b0, 32'h0, 32'h3010);
        redirect = 1'b0; imem_ack = 1'b0;
        tick();
        chk_out("bubble", 1'b1, 32'h3100, 1'b0, 32'h0, 32'h3010);

        // Redirect with request outstanding: old address kept until its ack.
        redirect = 1'b1; npc = 32'h3200;
        tick();
        chk_out("discard0", 1'b1, 32'h3100, 1'b0, 32'h0, 32'h3010);
        redirect = 1'b0;
        tick();
        chk_out("discard1", 1'b1, 32'h3100, 1'b0, 32'h0, 32'h3010);
        imem_ack = 1'b1;
        tick();
        chk_out("discard_ack", 1'b1, 32'h3200, 1'b0, 32'h0, 32'h3010);
        tick();
        chk_out("after_redir", 1'b1, 32'h3204, 1'b1, w(32'h3200), 32'h3204);

        // Stall beats redirect.
        stall = 1'b1; redirect = 1'b1; npc = 32'h4000; imem_ack = 1'b0;
        tick();
        chk_out("stall_redir", 1'b1, 32'h3204, 1'b1, w(32'h3200), 32'h3204);

        // Misaligned target forced to word; then wrap at top of address space.
        stall = 1'b0; npc = 32'hFFFF_FFFE;
        tick();
        chk_out("redir_top", 1'b1, 32'h3204, 1'b0, 32'h0, 32'h3204);
        redirect = 1'b0; imem_ack = 1'b1;
        tick();
        chk_out("fetch_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h3204);
        tick();
        chk_out("wrap", 1'b1, 32'h0, 1'b1, w(32'hFFFF_FFFC), 32'h0);

        // Reset mid-fetch abandons the request.
        rst = 1'b1;
        tick();
        chk_out("mid_reset", 1'b0, 32'h3000, 1'b0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
